// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux_arbiter_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GX   = 2'b01,
    GY   = 2'b10
  } state_t;

  typedef enum logic {
    SEL_X = 1'b0,
    SEL_Y = 1'b1
  } side_t;

  typedef logic [DATA_W-1:0] data_t;

  // Beat counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Producer/consumer bundle around the arbiter; master = environment, slave = arbiter.
interface mux_arbiter_if;
  import mux_arbiter_pkg::*;

  logic  req_x;
  data_t x_data;
  logic  req_y;
  data_t y_data;
  logic  out_ready;
  logic  gnt_x;
  logic  gnt_y;
  logic  sel;
  data_t z_data;
  logic  z_valid;

  modport master (
    output req_x, x_data, req_y, y_data, out_ready,
    input  gnt_x, gnt_y, sel, z_data, z_valid
  );

  modport slave (
    input  req_x, x_data, req_y, y_data, out_ready,
    output gnt_x, gnt_y, sel, z_data, z_valid
  );

endinterface

// File: rtl/mux_arbiter_mux.sv
// The lab's 4-bit 2:1 payload mux: sel=0 passes a (X), sel=1 passes b (Y).
module mux_arbiter_mux
  import mux_arbiter_pkg::*;
(
  input  data_t a,
  input  data_t b,
  input  logic  sel,
  output data_t y_c
);

  assign y_c = sel ? b : a;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner of the shared X/Y mux with a registered valid/ready output stage.
// Define MUX_ARB_HOLD_LIMIT_EN to force a switch after HOLD_MAX beats when the other side waits.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
)
(
  input  logic clk,
  input  logic rst,
  mux_arbiter_if.slave bus
);

  state_t state;
  side_t  last;
  data_t  z_data_q;
  logic   z_valid_q;
  data_t  mux_c;
  logic   own_req_c;
  logic   accept_c;
  logic   force_c;

  if ((HOLD_MAX < 1) || (HOLD_MAX > 15)) begin : g_bad_hold_max
    $error("mux_arbiter: HOLD_MAX must be within 1..15");
  end

  mux_arbiter_mux u_mux (
    .a   (bus.x_data),
    .b   (bus.y_data),
    .sel (bus.sel),
    .y_c (mux_c)
  );

  assign own_req_c = (state == GX) ? bus.req_x :
                     (state == GY) ? bus.req_y : 1'b0;
  assign accept_c  = own_req_c && (!z_valid_q || bus.out_ready);

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int unsigned CNT_X = CNT_W + 1;

  logic [CNT_W-1:0] hold_cnt;
  logic             other_req_c;

  assign other_req_c = (state == GX) ? bus.req_y : bus.req_x;
  assign force_c     = accept_c && other_req_c &&
                       ((CNT_X'(hold_cnt) + CNT_X'(1)) >= CNT_X'(HOLD_MAX));

  // Beats moved by the current owner; cleared whenever ownership ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (!own_req_c || force_c) begin
      hold_cnt <= '0;
    end else if (accept_c) begin
      hold_cnt <= sat_inc(hold_cnt);
    end
  end
`else
  assign force_c = 1'b0;
`endif

  // Ownership FSM and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= SEL_Y;
      z_data_q  <= '0;
      z_valid_q <= 1'b0;
    end else begin
      if (accept_c) begin
        z_data_q  <= mux_c;
        z_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        z_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.req_x && bus.req_y) begin
            state <= (last == SEL_Y) ? GX : GY;
          end else if (bus.req_x) begin
            state <= GX;
          end else if (bus.req_y) begin
            state <= GY;
          end
        end
        GX: begin
          if (!bus.req_x) begin
            last  <= SEL_X;
            state <= bus.req_y ? GY : IDLE;
          end else if (force_c) begin
            last  <= SEL_X;
            state <= GY;
          end
        end
        GY: begin
          if (!bus.req_y) begin
            last  <= SEL_Y;
            state <= bus.req_x ? GX : IDLE;
          end else if (force_c) begin
            last  <= SEL_Y;
            state <= GX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grants and select decode straight from the state flops.
  assign bus.gnt_x   = (state == GX);
  assign bus.gnt_y   = (state == GY);
  assign bus.sel     = (state == GY);
  assign bus.z_data  = z_data_q;
  assign bus.z_valid = z_valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: per-cycle check against a behavioural model plus literal spot checks.
module tb_mux_arbiter;

  localparam int unsigned HOLD_MAX = 4;
`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mux_arbiter_if bus ();

  mux_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // owner: 0 none, 1 X, 2 Y; last: side that most recently gave up ownership.
  typedef struct {
    int         owner;
    int         last;
    int         beats;
    logic [3:0] z;
    logic       v;
  } mdl_t;

  localparam mdl_t MDL_RESET = '{owner: 0, last: 2, beats: 0, z: 4'h0, v: 1'b0};

  mdl_t m;

  function automatic mdl_t step(mdl_t s, logic rx, logic [3:0] xd, logic ry,
                                logic [3:0] yd, logic rdy);
    mdl_t n = s;
    logic own = (s.owner == 1) ? rx : (s.owner == 2) ? ry : 1'b0;
    logic oth = (s.owner == 1) ? ry : rx;
    logic acc = own && (!s.v || rdy);
    if (acc) begin
      n.z     = (s.owner == 1) ? xd : yd;
      n.v     = 1'b1;
      n.beats = (s.beats < 15) ? s.beats + 1 : 15;
    end else if (rdy) begin
      n.v = 1'b0;
    end
    if (s.owner == 0) begin
      n.beats = 0;
      if (rx && ry)   n.owner = (s.last == 2) ? 1 : 2;
      else if (rx)    n.owner = 1;
      else if (ry)    n.owner = 2;
    end else if (!own) begin
      n.last  = s.owner;
      n.beats = 0;
      n.owner = oth ? 3 - s.owner : 0;
    end else if (LIMIT && acc && n.beats >= int'(HOLD_MAX) && oth) begin
      n.last  = s.owner;
      n.owner = 3 - s.owner;
      n.beats = 0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= MDL_RESET;
    else     m <= step(m, bus.req_x, bus.x_data, bus.req_y, bus.y_data, bus.out_ready);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_gnt_x",   8'(bus.gnt_x),   8'(m.owner == 1));
      chk("m_gnt_y",   8'(bus.gnt_y),   8'(m.owner == 2));
      chk("m_sel",     8'(bus.sel),     8'(m.owner == 2));
      chk("m_z_valid", 8'(bus.z_valid), 8'(m.v));
      chk("m_z_data",  8'(bus.z_data),  8'(m.z));
    end
  end

  task automatic cyc(input logic rx, input logic [3:0] xd, input logic ry,
                     input logic [3:0] yd, input logic rdy);
    bus.req_x = rx; bus.x_data = xd; bus.req_y = ry; bus.y_data = yd; bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_x = 1'b0; bus.req_y = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_gnt_x"},   8'(bus.gnt_x),   8'd0);
    chk({tag, "_gnt_y"},   8'(bus.gnt_y),   8'd0);
    chk({tag, "_sel"},     8'(bus.sel),     8'd0);
    chk({tag, "_z_data"},  8'(bus.z_data),  8'd0);
    chk({tag, "_z_valid"}, 8'(bus.z_valid), 8'd0);
  endtask

  initial begin
    int xi;
    bit seen_y;
    bus.req_x = 1'b0; bus.x_data = '0; bus.req_y = 1'b0; bus.y_data = '0; bus.out_ready = 1'b0;

    // Reset values, then a single X request.
    do_reset();
    chk_outs_zero("rst");
    cyc(1'b1, 4'd3, 1'b0, 4'd0, 1'b1);
    chk("x_grant", 8'(bus.gnt_x), 8'd1);
    chk("x_first_valid", 8'(bus.z_valid), 8'd0);
    cyc(1'b1, 4'd3, 1'b0, 4'd0, 1'b1);
    chk("x_data3", 8'(bus.z_data), 8'd3);
    chk("x_valid", 8'(bus.z_valid), 8'd1);
    chk("x_sel", 8'(bus.sel), 8'd0);

    // Both request after reset: X first, then direct handover to Y.
    do_reset();
    cyc(1'b1, 4'd5, 1'b1, 4'd6, 1'b1);
    chk("both_gnt_x", 8'(bus.gnt_x), 8'd1);
    cyc(1'b1, 4'd5, 1'b1, 4'd6, 1'b1);
    chk("both_x_data", 8'(bus.z_data), 8'd5);
    cyc(1'b0, 4'd0, 1'b1, 4'd6, 1'b1);
    chk("handover_gnt_y", 8'(bus.gnt_y), 8'd1);
    chk("handover_sel", 8'(bus.sel), 8'd1);
    cyc(1'b0, 4'd0, 1'b1, 4'd6, 1'b1);
    chk("handover_y_data", 8'(bus.z_data), 8'd6);
    chk("handover_y_valid", 8'(bus.z_valid), 8'd1);

    // Continuous contention: count X beats until Y is granted.
    do_reset();
    xi = 0;
    seen_y = 1'b0;
    for (int k = 0; k < 20 && !seen_y; k++) begin
      logic gx_before;
      logic rx;
      gx_before = bus.gnt_x;
      rx = (xi < 8);
      cyc(rx, 4'(xi + 1), 1'b1, 4'hA, 1'b1);
      if (gx_before && rx) xi++;
      if (bus.gnt_y) seen_y = 1'b1;
    end
    chk("hold_y_granted", 8'(seen_y), 8'd1);
    chk("hold_x_beats", 8'(xi), LIMIT ? 8'(HOLD_MAX) : 8'd8);
    cyc(1'b0, 4'd0, 1'b1, 4'hA, 1'b1);
    chk("hold_y_data", 8'(bus.z_data), 8'hA);

    // Backpressure holds the pending beat.
    do_reset();
    cyc(1'b1, 4'd9, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 4'd9, 1'b0, 4'd0, 1'b0);
    chk("stall_load9", 8'(bus.z_data), 8'd9);
    for (int k = 0; k < 3; k++) cyc(1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
    chk("stall_hold9", 8'(bus.z_data), 8'd9);
    chk("stall_valid", 8'(bus.z_valid), 8'd1);
    cyc(1'b1, 4'd2, 1'b0, 4'd0, 1'b1);
    chk("stall_next2", 8'(bus.z_data), 8'd2);

    // Asynchronous reset in the middle of a Y burst.
    do_reset();
    cyc(1'b0, 4'd0, 1'b1, 4'd7, 1'b1);
    cyc(1'b0, 4'd0, 1'b1, 4'd7, 1'b1);
    chk("gy_data7", 8'(bus.z_data), 8'd7);
    rst = 1'b1;
    #1;
    chk_outs_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 4'd1, 1'b1, 4'd2, 1'b1);
    chk("post_rst_gnt_x", 8'(bus.gnt_x), 8'd1);

    // Idle with a pending beat: drains on the first ready.
    do_reset();
    cyc(1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    chk("idle_pending", 8'(bus.z_valid), 8'd1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    chk("idle_drained", 8'(bus.z_valid), 8'd0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    chk("idle_gnt_x", 8'(bus.gnt_x), 8'd0);
    chk("idle_gnt_y", 8'(bus.gnt_y), 8'd0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
